// File: rtl/ad5543_sched_pkg.sv
// Shared types and helpers for the AD5543 round-robin bus scheduler.
package ad5543_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int DW_DEF    = 16;
  localparam int DIV_DEF   = 1;
  localparam int FRAME_CYC = 2 * DW_DEF * DIV_DEF;

  // Index width that never collapses to zero bits, so NCH=1 still has a grant_id.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ad5543_serializer.sv
// Shifts one DW-bit word MSB first onto sclk/sdi; sclk half-period is DIV aclk cycles.
module ad5543_serializer
  import ad5543_sched_pkg::*;
#(
  parameter int DW  = 16,
  parameter int DIV = 1
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          start,
  input  logic [DW-1:0] data,
  output logic          sclk,
  output logic          sdi,
  output logic          active,
  output logic          done
);

  localparam int DCW = clog2_min1(DIV);
  localparam int HCW = clog2_min1(2 * DW);

  logic [DW-1:0]  shreg;
  logic [DCW-1:0] div_cnt;
  logic [HCW-1:0] half_cnt;
  logic           tick;

  assign tick = active && (div_cnt == '0);
  // done marks the last cycle of the frame; the next edge drops sclk and active together
  assign done = tick && (half_cnt == '0);
  assign sdi  = active & shreg[DW-1];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      shreg    <= '0;
      div_cnt  <= '0;
      half_cnt <= '0;
      sclk     <= 1'b0;
      active   <= 1'b0;
    end else if (start) begin
      shreg    <= data;
      div_cnt  <= DCW'(DIV - 1);
      half_cnt <= HCW'(2 * DW - 1);
      sclk     <= 1'b0;
      active   <= 1'b1;
    end else if (tick) begin
      div_cnt <= DCW'(DIV - 1);
      if (done) begin
        active <= 1'b0;
        sclk   <= 1'b0;
      end else begin
        half_cnt <= half_cnt - HCW'(1);
        sclk     <= ~sclk;
        if (sclk) shreg <= {shreg[DW-2:0], 1'b0};
      end
    end else if (active) begin
      div_cnt <= div_cnt - DCW'(1);
    end
  end

endmodule

// File: rtl/ad5543_rr_scheduler.sv
// Round-robin sharing of one AD5543 serial bus between NCH AXI-stream sources.
// Optional per-channel frame counters when AD5543_SCHED_STAT_EN is defined.
//
// state | meaning
// IDLE  | waiting for en and a valid source; tready offered to the winner
// SHIFT | frame in flight, cs_n of grant_id low
// GAP   | all cs_n high for GAP_CYC cycles before the next grant
module ad5543_rr_scheduler
  import ad5543_sched_pkg::*;
#(
  parameter  int DW      = 16,
  parameter  int NCH     = 4,
  parameter  int DIV     = 1,
  parameter  int GAP_CYC = 2,
  localparam int GW      = clog2_min1(NCH)
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              en,
  input  logic [NCH-1:0]    s_axis_tvalid,
  output logic [NCH-1:0]    s_axis_tready,
  input  logic [NCH*DW-1:0] s_axis_tdata,
`ifdef AD5543_SCHED_STAT_EN
  output logic [NCH*16-1:0] frame_cnt,
`endif
  output logic              sclk,
  output logic              sdi,
  output logic [NCH-1:0]    cs_n,
  output logic              busy,
  output logic [GW-1:0]     grant_id
);

  localparam int GCW = clog2_min1(GAP_CYC);

  state_t         state;
  logic [GW-1:0]  ptr;
  logic [GW-1:0]  winner;
  logic           found;
  logic           take;
  logic [GCW-1:0] gap_cnt;
  logic [DW-1:0]  win_data;
  logic           ser_active;
  logic           ser_done;

  always_comb begin
    int            sum;
    logic [GW-1:0] idx;
    found  = 1'b0;
    winner = '0;
    sum    = 0;
    idx    = '0;
    for (int i = 0; i < NCH; i++) begin
      sum = int'(ptr) + i;
      if (sum >= NCH) sum = sum - NCH;
      idx = sum[GW-1:0];
      if (!found && s_axis_tvalid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // tready is also masked during reset so no handshake can be seen while aresetn is low
  assign take     = aresetn && (state == IDLE) && en && found;
  assign win_data = s_axis_tdata[int'(winner)*DW +: DW];
  assign busy     = (state != IDLE);

  always_comb begin
    s_axis_tready = '0;
    if (take) s_axis_tready[winner] = 1'b1;
  end

  ad5543_serializer #(
    .DW  (DW),
    .DIV (DIV)
  ) u_ser (
    .aclk    (aclk),
    .aresetn (aresetn),
    .start   (take),
    .data    (win_data),
    .sclk    (sclk),
    .sdi     (sdi),
    .active  (ser_active),
    .done    (ser_done)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE;
      ptr      <= '0;
      grant_id <= '0;
      cs_n     <= '1;
      gap_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            state        <= SHIFT;
            grant_id     <= winner;
            ptr          <= (winner == GW'(NCH - 1)) ? '0 : winner + GW'(1);
            cs_n[winner] <= 1'b0;
          end
        end
        SHIFT: begin
          if (ser_done) begin
            state   <= GAP;
            cs_n    <= '1;
            gap_cnt <= GCW'(GAP_CYC - 1);
          end
        end
        GAP: begin
          if (gap_cnt == '0) state <= IDLE;
          else gap_cnt <= gap_cnt - GCW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AD5543_SCHED_STAT_EN
  logic [15:0] cnt [NCH];

  // counts only frames that reach their final cs_n edge; reset discards partial frames
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int c = 0; c < NCH; c++) cnt[c] <= '0;
    end else if (ser_done && ser_active) begin
      cnt[grant_id] <= cnt[grant_id] + 16'd1;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_cnt
    assign frame_cnt[c*16 +: 16] = cnt[c];
  end
`endif

endmodule

// File: tb/tb_ad5543_rr_scheduler.sv
// Self-checking bench for ad5543_rr_scheduler: timeline model of grants/frames plus a DAC-side word capture.
`timescale 1ns/1ps
module tb_ad5543_rr_scheduler;
  import ad5543_sched_pkg::*;

  localparam int DW      = 16;
  localparam int NCH     = 4;
  localparam int DIV     = 1;
  localparam int GAP_CYC = 2;
  localparam int GW      = clog2_min1(NCH);
  localparam int FRAME   = FRAME_CYC;

  logic              aclk;
  logic              aresetn;
  logic              en;
  logic [NCH-1:0]    tvalid;
  logic [NCH-1:0]    tready;
  logic [NCH*DW-1:0] tdata;
  logic              sclk;
  logic              sdi;
  logic [NCH-1:0]    cs_n;
  logic              busy;
  logic [GW-1:0]     grant_id;
`ifdef AD5543_SCHED_STAT_EN
  logic [NCH*16-1:0] frame_cnt;
`endif

  ad5543_rr_scheduler #(
    .DW      (DW),
    .NCH     (NCH),
    .DIV     (DIV),
    .GAP_CYC (GAP_CYC)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .en            (en),
    .s_axis_tvalid (tvalid),
    .s_axis_tready (tready),
    .s_axis_tdata  (tdata),
`ifdef AD5543_SCHED_STAT_EN
    .frame_cnt     (frame_cnt),
`endif
    .sclk          (sclk),
    .sdi           (sdi),
    .cs_n          (cs_n),
    .busy          (busy),
    .grant_id      (grant_id)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;

  longint        cyc = 0;
  longint        m_t0 = -1000;
  int            m_g = 0;
  int            m_ptr = 0;
  logic [DW-1:0] m_data = '0;
  int            m_cnt [NCH];

  logic [DW-1:0]  cap [NCH];
  int             nbits [NCH];
  logic [DW-1:0]  dac_exp = '0;
  int             dac_ch = 0;
  logic           prev_sclk = 1'b0;
  logic [NCH-1:0] prev_cs = '1;
  logic [DW-1:0]  last_word = '0;

  int o_tready = 0, o_cs0_low = 0, o_cs_other = 0, o_rise = 0, o_busy = 0;

  int     g_ch [$];
  longint g_cyc [$];

  int exp_seq [5] = '{0, 1, 2, 3, 0};
  int exp_wrap [3] = '{3, 0, 2};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected outputs are derived from the cycle offset since the last grant.
  task automatic monitor();
    logic [NCH-1:0] e_cs, e_rdy;
    logic           e_sclk, e_sdi, e_busy;
    longint         p;
    int             w, idx;
    cyc++;
    if (!aresetn) begin
      m_t0 = -1000; m_g = 0; m_ptr = 0;
      for (int c = 0; c < NCH; c++) begin m_cnt[c] = 0; nbits[c] = 0; end
      chk("rst_cs_n", cs_n, {NCH{1'b1}});
      chk("rst_sclk", sclk, 0);
      chk("rst_sdi", sdi, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tready", tready, 0);
      chk("rst_grant_id", grant_id, 0);
`ifdef AD5543_SCHED_STAT_EN
      chk("rst_frame_cnt", frame_cnt, 0);
`endif
      prev_cs = '1; prev_sclk = 1'b0;
      return;
    end
    p = cyc - m_t0;
    e_cs = '1; e_sclk = 1'b0; e_sdi = 1'b0; e_busy = 1'b0; e_rdy = '0;
    if (p >= 1 && p <= FRAME) begin
      e_cs[m_g] = 1'b0;
      e_sclk = ((((p - 1) / DIV) % 2) == 1);
      e_sdi  = m_data[DW - 1 - int'((p - 1) / (2 * DIV))];
    end
    if (p >= 1 && p < FRAME + 1 + GAP_CYC) e_busy = 1'b1;
    if (p == FRAME + 1) m_cnt[m_g] = (m_cnt[m_g] + 1) % 65536;
    w = -1;
    if (!e_busy && en && (|tvalid)) begin
      for (int k = 0; k < NCH; k++) begin
        idx = (m_ptr + k) % NCH;
        if (w < 0 && tvalid[idx]) w = idx;
      end
    end
    if (w >= 0) e_rdy[w] = 1'b1;
    chk("cs_n", cs_n, e_cs);
    chk("sclk", sclk, e_sclk);
    chk("sdi", sdi, e_sdi);
    chk("busy", busy, e_busy);
    chk("tready", tready, e_rdy);
    chk("grant_id", grant_id, m_g);
`ifdef AD5543_SCHED_STAT_EN
    for (int c = 0; c < NCH; c++) chk("frame_cnt", frame_cnt[c*16 +: 16], m_cnt[c]);
`endif
    if (w >= 0) begin
      m_t0 = cyc; m_g = w; m_ptr = (w + 1) % NCH;
      m_data = tdata[w*DW +: DW];
      dac_exp = m_data; dac_ch = w;
      g_ch.push_back(w); g_cyc.push_back(cyc);
    end
    for (int c = 0; c < NCH; c++) begin
      if (prev_cs[c] && !cs_n[c]) begin cap[c] = '0; nbits[c] = 0; end
      if (!cs_n[c] && sclk && !prev_sclk) begin
        cap[c] = {cap[c][DW-2:0], sdi};
        nbits[c]++;
      end
      if (!prev_cs[c] && cs_n[c]) begin
        chk("dac_word", cap[c], dac_exp);
        chk("dac_bits", nbits[c], DW);
        chk("dac_channel", c, dac_ch);
        last_word = cap[c];
      end
    end
    o_tready   += int'(|tready);
    o_cs0_low  += int'(!cs_n[0]);
    o_cs_other += int'(cs_n[NCH-1:1] != '1);
    o_rise     += int'(sclk && !prev_sclk);
    o_busy     += int'(busy);
    prev_sclk = sclk;
    prev_cs   = cs_n;
  endtask

  task automatic step();
    @(negedge aclk);
    monitor();
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_grant(input int target, input int budget);
    int b;
    b = 0;
    while (g_ch.size() < target && b < budget) begin step(); b++; end
    if (g_ch.size() < target) chk("grant_timeout", 0, 1);
  endtask

  task automatic do_reset();
    aresetn = 1'b0; tvalid = '0;
    step(); step();
    aresetn = 1'b1;
  endtask

  initial begin
    int base, b, n0, s_t, s_c0, s_co, s_r, s_b;
    longint t0, rise;
    aresetn = 1'b0; en = 1'b0; tvalid = '0; tdata = '0;
    @(posedge aclk); #1;
    step(); step();
    chk("reset_cs_n", cs_n, {NCH{1'b1}});
    chk("reset_busy", busy, 0);
    chk("reset_grant_id", grant_id, 0);

    // single frame on ch0
    aresetn = 1'b1; en = 1'b1;
    tdata[0 +: DW] = 16'hA5C3; tvalid = 4'b0001;
    s_t = o_tready; s_c0 = o_cs0_low; s_co = o_cs_other; s_r = o_rise; s_b = o_busy;
    base = g_ch.size();
    wait_grant(base + 1, 10);
    tvalid = '0;
    repeat (45) step();
    chk("single_tready_cycles", o_tready - s_t, 1);
    chk("single_cs0_low_cycles", o_cs0_low - s_c0, 32);
    chk("single_other_cs_low", o_cs_other - s_co, 0);
    chk("single_sclk_rises", o_rise - s_r, 16);
    chk("single_busy_cycles", o_busy - s_b, 34);
    chk("single_word", last_word, 16'hA5C3);

    // all channels valid continuously
    do_reset(); en = 1'b1;
    for (int c = 0; c < NCH; c++) tdata[c*DW +: DW] = DW'($urandom);
    tvalid = '1; base = g_ch.size(); b = 0;
    while (g_ch.size() < base + 5 && b < 400) begin
      n0 = g_ch.size();
      step(); b++;
      if (g_ch.size() > n0) tdata[g_ch[g_ch.size()-1]*DW +: DW] = DW'($urandom);
    end
    tvalid = '0;
    if (g_ch.size() < base + 5) chk("rr_timeout", 0, 1);
    else begin
      for (int i = 0; i < 5; i++) chk("rr_grant_seq", g_ch[base+i], exp_seq[i]);
      for (int i = 1; i < 5; i++) chk("rr_start_spacing", g_cyc[base+i] - g_cyc[base+i-1], 35);
    end
    repeat (40) step();

    // wrap of the pointer after ch3
    do_reset(); en = 1'b1;
    for (int c = 0; c < NCH; c++) tdata[c*DW +: DW] = DW'($urandom);
    tvalid = 4'b1000; base = g_ch.size();
    wait_grant(base + 1, 10);
    tvalid = 4'b0101;
    wait_grant(base + 2, 60);
    if (g_ch.size() > base + 1) tvalid[g_ch[base+1]] = 1'b0;
    wait_grant(base + 3, 60);
    tvalid = '0;
    if (g_ch.size() >= base + 3)
      for (int i = 0; i < 3; i++) chk("wrap_grant_seq", g_ch[base+i], exp_wrap[i]);
    repeat (40) step();

    // en dropped at sclk rising edge 5
    do_reset(); en = 1'b1;
    tdata[1*DW +: DW] = DW'($urandom); tvalid = 4'b0010; base = g_ch.size();
    wait_grant(base + 1, 10);
    tvalid = '0;
    t0 = (g_ch.size() > base) ? g_cyc[base] : cyc;
    b = 0;
    while (cyc < t0 + 9 && b < 20) begin step(); b++; end
    en = 1'b0; tvalid = 4'b0010; tdata[1*DW +: DW] = DW'($urandom);
    s_t = o_tready;
    repeat (60) step();
    chk("en_low_no_tready", o_tready - s_t, 0);
    en = 1'b1; rise = cyc + 1;
    wait_grant(base + 2, 5);
    tvalid = '0;
    if (g_ch.size() >= base + 2) begin
      chk("en_rise_grant_cycle", g_cyc[base+1], rise);
      chk("en_rise_grant_ch", g_ch[base+1], 1);
    end
    repeat (40) step();

    // reset asserted at sclk rising edge 8
    do_reset(); en = 1'b1;
    tdata[2*DW +: DW] = DW'($urandom); tvalid = 4'b0100; base = g_ch.size();
    wait_grant(base + 1, 10);
    tvalid = '0;
    t0 = (g_ch.size() > base) ? g_cyc[base] : cyc;
    b = 0;
    while (cyc < t0 + 15 && b < 20) begin step(); b++; end
    chk("pre_reset_cs2_low", cs_n[2], 0);
    aresetn = 1'b0;
    #1;
    chk("midrst_cs_n", cs_n, {NCH{1'b1}});
    chk("midrst_sclk", sclk, 0);
    chk("midrst_sdi", sdi, 0);
    chk("midrst_busy", busy, 0);
    step();
    for (int c = 0; c < NCH; c++) tdata[c*DW +: DW] = DW'($urandom);
    tvalid = '1;
    step();
    aresetn = 1'b1; base = g_ch.size();
    wait_grant(base + 1, 5);
    tvalid = '0;
    if (g_ch.size() > base) chk("post_reset_first_grant", g_ch[base], 0);
    repeat (40) step();

    // randomized traffic with occasional resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      en      = ($urandom % 8) != 0;
      tvalid  = NCH'($urandom) & NCH'($urandom);
      tdata   = {$urandom, $urandom};
      aresetn = ($urandom % 1000) != 0;
      step();
    end
    aresetn = 1'b1; tvalid = '0;
    repeat (40) step();

`ifdef AD5543_SCHED_STAT_EN
    do_reset(); en = 1'b1;
    tdata[2*DW +: DW] = DW'($urandom); tvalid = 4'b0100; base = g_ch.size();
    wait_grant(base + 3, 150);
    tvalid = '0;
    repeat (40) step();
    for (int c = 0; c < NCH; c++) chk("stat_frame_cnt", frame_cnt[c*16 +: 16], (c == 2) ? 3 : 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
